jtag_amm_cmd_master: RTL and testbench

JTAG_AMM_CMD_MASTER -- requirements
Module: jtag_amm_cmd_master

---
 rtl/jtag_amm_pkg.sv | 19 +
 rtl/jtag_amm_cmd_master.sv | 152 +++++++++++++++
 tb/tb_jtag_amm_cmd_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_amm_pkg.sv
// Shared command/response codes and FSM state encoding for the JTAG-to-Avalon-MM command master.
package jtag_amm_pkg;

    localparam logic [7:0] CMD_WR  = 8'h00;
    localparam logic [7:0] CMD_RD  = 8'h01;
    localparam logic [7:0] RSP_OK  = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        IDLE_S,
        ADDR_S,
        WDATA_S,
        WR_S,
        RD_S,
        RD_WAIT_S,
        RESP_S
    } state_t;

endpackage

// File: rtl/jtag_amm_cmd_master.sv
// Byte-stream command decoder driving one Avalon-MM master access per frame.
// Optional macro CMD_TIMEOUT_EN adds a read-response timeout (TIMEOUT_CYC cycles -> 0xEE).
module jtag_amm_cmd_master
    import jtag_amm_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [ADDR_W-1:0]   amm_address_o,
    output logic                amm_read_o,
    output logic                amm_write_o,
    output logic [DATA_W-1:0]   amm_writedata_o,
    output logic [DATA_W/8-1:0] amm_byteenable_o,
    input  logic [DATA_W-1:0]   amm_readdata_i,
    input  logic                amm_readdatavalid_i,
    input  logic                amm_waitrequest_i
);

    localparam int ADDR_B = ADDR_W / 8;
    localparam int DATA_B = DATA_W / 8;
    localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
    localparam int CNT_W  = $clog2(MAX_B) + 1;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    resp_last;
    logic [DATA_W-1:0]   resp_buf;
    logic                is_read;
`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    // Gated with rst_i so no byte is taken while reset is asserted.
    assign rx_ready_o = !rst_i &&
                        (state == IDLE_S || state == ADDR_S || state == WDATA_S);
    assign amm_byteenable_o = '1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE_S;
            cnt             <= '0;
            resp_last       <= '0;
            resp_buf        <= '0;
            is_read         <= 1'b0;
            amm_address_o   <= '0;
            amm_writedata_o <= '0;
            amm_read_o      <= 1'b0;
            amm_write_o     <= 1'b0;
            tx_data_o       <= '0;
            tx_valid_o      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE_S: if (rx_valid_i) begin
                    cnt <= '0;
                    if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                        is_read <= (rx_data_i == CMD_RD);
                        state   <= ADDR_S;
                    end else begin
                        tx_data_o  <= RSP_ERR;
                        tx_valid_o <= 1'b1;
                        resp_last  <= '0;
                        state      <= RESP_S;
                    end
                end
                ADDR_S: if (rx_valid_i) begin
                    // LSB-first: each new byte enters at the top and shifts down.
                    amm_address_o <= ADDR_W'({rx_data_i, amm_address_o} >> 8);
                    if (cnt == CNT_W'(ADDR_B - 1)) begin
                        cnt <= '0;
                        if (is_read) begin
                            amm_read_o <= 1'b1;
                            state      <= RD_S;
                        end else begin
                            state <= WDATA_S;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WDATA_S: if (rx_valid_i) begin
                    amm_writedata_o <= DATA_W'({rx_data_i, amm_writedata_o} >> 8);
                    if (cnt == CNT_W'(DATA_B - 1)) begin
                        cnt         <= '0;
                        amm_write_o <= 1'b1;
                        state       <= WR_S;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_S: if (!amm_waitrequest_i) begin
                    amm_write_o <= 1'b0;
                    tx_data_o   <= RSP_OK;
                    tx_valid_o  <= 1'b1;
                    resp_last   <= '0;
                    state       <= RESP_S;
                end
                RD_S: if (!amm_waitrequest_i) begin
                    amm_read_o <= 1'b0;
                    state      <= RD_WAIT_S;
`ifdef CMD_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end
                RD_WAIT_S: begin
                    if (amm_readdatavalid_i) begin
                        tx_data_o  <= amm_readdata_i[7:0];
                        resp_buf   <= amm_readdata_i >> 8;
                        tx_valid_o <= 1'b1;
                        resp_last  <= CNT_W'(DATA_B - 1);
                        state      <= RESP_S;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        tx_data_o  <= RSP_ERR;
                        tx_valid_o <= 1'b1;
                        resp_last  <= '0;
                        state      <= RESP_S;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP_S: if (tx_valid_o && tx_ready_i) begin
                    if (cnt == resp_last) begin
                        cnt        <= '0;
                        tx_valid_o <= 1'b0;
                        state      <= IDLE_S;
                    end else begin
                        tx_data_o <= resp_buf[7:0];
                        resp_buf  <= resp_buf >> 8;
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_amm_cmd_master.sv
// Directed bench for jtag_amm_cmd_master (32-bit address/data); timeout steps need CMD_TIMEOUT_EN.
module tb_jtag_amm_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] amm_address;
    logic        amm_read;
    logic        amm_write;
    logic [31:0] amm_writedata;
    logic [3:0]  amm_byteenable;
    logic [31:0] amm_readdata;
    logic        amm_readdatavalid;
    logic        amm_waitrequest;

    int total = 0;
    int bad   = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int both_high = 0;

    jtag_amm_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .rx_data_i           (rx_data),
        .rx_valid_i          (rx_valid),
        .rx_ready_o          (rx_ready),
        .tx_data_o           (tx_data),
        .tx_valid_o          (tx_valid),
        .tx_ready_i          (tx_ready),
        .amm_address_o       (amm_address),
        .amm_read_o          (amm_read),
        .amm_write_o         (amm_write),
        .amm_writedata_o     (amm_writedata),
        .amm_byteenable_o    (amm_byteenable),
        .amm_readdata_i      (amm_readdata),
        .amm_readdatavalid_i (amm_readdatavalid),
        .amm_waitrequest_i   (amm_waitrequest)
    );

    always #5 clk = ~clk;

    // Request cycle counters sampled mid-cycle.
    always @(negedge clk) begin
        if (amm_write) wr_cycles++;
        if (amm_read) rd_cycles++;
        if (amm_read && amm_write) both_high++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("rx_ready_timeout", 64'd0, 64'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk({tag, "_tx_timeout"}, 64'd0, 64'd1);
        else chk(tag, {56'd0, tx_data}, {56'd0, exp});
        step();
    endtask

    initial begin
        int wr0, rd0;
        rst = 1'b1;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
        amm_readdata = '0; amm_readdatavalid = 1'b0; amm_waitrequest = 1'b0;
        step(); step();

        // Reset state
        chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_amm_read", {63'd0, amm_read}, 64'd0);
        chk("rst_amm_write", {63'd0, amm_write}, 64'd0);
        chk("rst_address", {32'd0, amm_address}, 64'd0);
        chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_rx_ready", {63'd0, rx_ready}, 64'd1);

        // Write with 3 cycles of waitrequest
        amm_waitrequest = 1'b1;
        wr0 = wr_cycles;
        send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("wr_first_cycle", {63'd0, amm_write}, 64'd1);
        chk("wr_address", {32'd0, amm_address}, 64'h12345678);
        chk("wr_data", {32'd0, amm_writedata}, 64'hDEADBEEF);
        chk("wr_byteenable", {60'd0, amm_byteenable}, 64'hF);
        chk("wr_rx_ready_low", {63'd0, rx_ready}, 64'd0);
        step(); step(); step();
        chk("wr_held", {63'd0, amm_write}, 64'd1);
        chk("wr_addr_stable", {32'd0, amm_address}, 64'h12345678);
        amm_waitrequest = 1'b0;
        step();
        chk("wr_dropped", {63'd0, amm_write}, 64'd0);
        chk("wr_cycles", 64'(wr_cycles - wr0), 64'd4);
        recv_byte("wr_resp", 8'hA5);
        chk("wr_resp_done", {63'd0, tx_valid}, 64'd0);

        // Read with tx backpressure
        rd0 = rd_cycles;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        chk("rd_asserted", {63'd0, amm_read}, 64'd1);
        chk("rd_address", {32'd0, amm_address}, 64'h00001000);
        step();
        chk("rd_dropped", {63'd0, amm_read}, 64'd0);
        step(); step(); step();
        chk("rd_wait_no_tx", {63'd0, tx_valid}, 64'd0);
        tx_ready = 1'b0;
        amm_readdata = 32'hCAFEBABE;
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        amm_readdata = 32'h0;
        chk("rd_cycles", 64'(rd_cycles - rd0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_tx_valid", {63'd0, tx_valid}, 64'd1);
            chk("bp_tx_data", {56'd0, tx_data}, 64'hBE);
            chk("bp_rx_ready", {63'd0, rx_ready}, 64'd0);
            step();
        end
        recv_byte("rd_b0", 8'hBE);
        recv_byte("rd_b1", 8'hBA);
        recv_byte("rd_b2", 8'hFE);
        recv_byte("rd_b3", 8'hCA);
        chk("rd_resp_done", {63'd0, tx_valid}, 64'd0);

        // Stray readdatavalid while idle, then invalid command
        wr0 = wr_cycles; rd0 = rd_cycles;
        amm_readdata = 32'h11111111;
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        chk("stray_rdv_ignored", {63'd0, tx_valid}, 64'd0);
        send_byte(8'h7F);
        recv_byte("inv_resp", 8'hEE);
        step();
        chk("inv_single_byte", {63'd0, tx_valid}, 64'd0);
        chk("inv_no_write", 64'(wr_cycles - wr0), 64'd0);
        chk("inv_no_read", 64'(rd_cycles - rd0), 64'd0);

        // Reset during RD_WAIT_S
        send_byte(8'h01);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        chk("rst_rd_address", {32'd0, amm_address}, 64'h11223344);
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_amm_read", {63'd0, amm_read}, 64'd0);
        chk("midrst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("midrst_rx_ready", {63'd0, rx_ready}, 64'd0);
        step();
        rst = 1'b0;
        amm_readdata = 32'h55555555;
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        chk("postrst_rdv_ignored", {63'd0, tx_valid}, 64'd0);
        wr0 = wr_cycles;
        send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("postrst_wr_addr", {32'd0, amm_address}, 64'h00000004);
        chk("postrst_wr_data", {32'd0, amm_writedata}, 64'h12345678);
        step();
        chk("postrst_wr_cycles", 64'(wr_cycles - wr0), 64'd1);
        recv_byte("postrst_resp", 8'hA5);

`ifdef CMD_TIMEOUT_EN
        // Read timeout with TIMEOUT_CYC=16
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("tmo_not_yet", {63'd0, tx_valid}, 64'd0);
        step();
        chk("tmo_fired", {63'd0, tx_valid}, 64'd1);
        recv_byte("tmo_resp", 8'hEE);
        amm_readdata = 32'h12121212;
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        step(); step();
        chk("tmo_late_rdv_ignored", {63'd0, tx_valid}, 64'd0);
`endif

        chk("never_both_high", 64'(both_high), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
